topk_angle_sorter: RTL and testbench
====================================

# topk_angle_sorter

Parametrised successor of the fixed ten-slot angle sorter in the match pipeline. Per candidate angle it accumulates `alpha_num` per-alpha scores, quantises the sum to a compare key, and inserts (angle, key) into a descending top-K list. It delivers the list through a valid/ready handshake at the end of each sweep. Angle travels with its score, so the block needs no fixed external delay line; list depth, key slice and active depth are configurable.

## Interface
- `SCORE_W`, 21: per-alpha score width.
- `ACC_W`, 21: accumulator width; saturating.
- `KEY_W`, 8: compare key width.
- `KEY_LSB`, 12: key is `acc[KEY_LSB+KEY_W-1:KEY_LSB]`, saturated to all-ones if any higher bit is set.
- `K`, 10: maximum list depth (1..16).
- `ANGLE_W`, 24: packed `{theta, phi}` width.
- `ALPHA_W`, 9: `alpha_num` width.
- `clk  in  1`: clock.
- `rst  in  1`: asynchronous, active-high reset.
- `score_valid  in  1`: one alpha score present.
- `score  in  SCORE_W`: per-alpha score.
- `angle  in  ANGLE_W`: angle of the current group; sampled on the group's first valid score.
- `alpha_num  in  ALPHA_W`: scores per angle; 0 is treated as 1.
- `k_active  in  5`: active depth; 0 is treated as 1, values above K become K.
- `last_angle  in  1`: qualified by `score_valid`; marks the current group as the final group of the sweep.
- `result_ready  in  1`: consumer accepts the result.
- `result_valid  out  1`: result registers hold a completed sweep.
- `result_angles  out  K*ANGLE_W`: slot 0 is in the LSBs and holds the best entry.
- `result_keys  out  K*KEY_W`: keys aligned with `result_angles`.
- `result_count  out  5`: number of valid slots, at most `k_active`.
- `overrun  out  1`: sticky; a new result overwrote an unaccepted one.
- `busy  out  1`: a sweep is in progress (group open or insert pending).

## Operation
- Accumulator:
  - On the first valid score of a group: `acc = score` (zero-extended), latch `angle`, `cnt = 1`.
  - On each later valid score: `acc = sat(acc + score)`, `cnt++`.
  - Gaps in `score_valid` hold all state.
- Group end is the valid score where `cnt` reaches the effective `alpha_num`. At group end:
  - Form `key` from the final sum including that score.
  - Register candidate `{angle, key, last}`.
  - Reset `cnt` to 0.
- `last_angle` is sticky within a group and applied at group end.
- `k_active` is latched on the first score of each sweep and held for the whole sweep.
- List update:
  - Each slot holds `{v, angle, key}`. Invalid slots rank below everything.
  - Insert position `p` = number of valid slots with `key >= cand_key`, so ties keep the earlier entry.
  - If `p < k_eff`: slots `p..k_eff-2` shift down one, slot `p` takes the candidate, and the entry in `k_eff-1` is dropped.
  - Otherwise the candidate is discarded.
  - One insert per cycle, combinational compare, registered update.
- FSM states: IDLE, RUN.
  - IDLE → RUN on the first valid score.
  - RUN → IDLE in the cycle the last candidate is inserted. In that same cycle:
    - Copy the list to the result registers.
    - Set `result_valid`.
    - Clear the list.
- A new sweep may start in that same cycle; its scores feed the accumulator normally.
- Handshake: `result_valid && result_ready` clears `result_valid` at the next edge. Result data is held while valid.
- Overrun: if a new completion arrives while `result_valid` is high and `result_ready` is low:
  - The result is overwritten.
  - `overrun` sets and stays set until reset.
  - If `result_ready` is high in the same cycle, there is no overrun and `result_valid` stays 1.

## Timing
- Final score of a group at cycle t → candidate registered at t+1 → list visible at t+2.
- For the last group, `result_valid` and result data are visible at t+2.
- With `alpha_num = 1`, a full-rate stream is sustained: one candidate per cycle with no stall. Back-to-back inserts see the previously updated list.
- Reset (any time, including mid-sweep or mid-handshake) clears everything to 0 and drops any partial group:
  - all list slots;
  - accumulator and counter;
  - FSM to IDLE;
  - `result_*` outputs, `overrun` and `busy`.
- Wrap-around: the accumulator saturates at 2^ACC_W-1 and never wraps. `cnt` width is ALPHA_W.

## Structure
- Package `topk_pkg`: default parameters, the FSM state enum, and functions `key_sat()` and `k_clamp()`.
- Sub-module `topk_insert_list`: slot registers, comparators, shift-insert, clear and snapshot. Parameters: `K`, `KEY_W`, `ANGLE_W`.
- Top level: accumulator, candidate register, FSM, result handshake.

## Test plan
- Config `alpha_num=2`, `K=10`, `k_active=10`, `KEY_LSB=0`. Stimulus: 3 angles with key sums 5, 9, 5, last flag on the third group. Required: slots `[9, 5(first angle), 5(third angle)]`, `result_count=3`, `result_valid` at t+2.
- Config `k_active=3`. Stimulus: 12 angles with keys 1..12. Required: result keys `[12, 11, 10]`, `result_count=3`, slots 3..9 invalid and zero.
- Config `alpha_num=4`, `KEY_LSB=12`. Stimulus: scores 0x1FFFFF ×4. Required: accumulator saturates and key=0xFF.
- Config `alpha_num=1`. Stimulus: continuous stream of keys 3,7,7,1 with last on the fourth; then a second sweep starting the next cycle. Required: first result `[7, 7, 3, 1]` with tie order preserved; second sweep starts from an empty list.
- Stimulus: `result_ready=0` across two sweep completions. Required: `overrun=1` and the result holds the second sweep. Then assert `result_ready=1`: `result_valid` clears next cycle.
- Stimulus: assert `rst` mid-group and mid-sweep. Required: all outputs 0 and `busy=0`. The next sweep's results are unaffected by pre-reset data.

Source files
------------

// File: rtl/topk_pkg.sv
// rtl/topk_pkg.sv - shared parameters, FSM state type and key/depth helpers for the top-K angle sorter
package topk_pkg;

  localparam int SCORE_W_DEF = 21;
  localparam int ACC_W_DEF   = 21;
  localparam int KEY_W_DEF   = 8;
  localparam int KEY_LSB_DEF = 12;
  localparam int K_DEF       = 10;
  localparam int ANGLE_W_DEF = 24;
  localparam int ALPHA_W_DEF = 9;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Slice kw bits starting at lsb; any set bit above the slice saturates the key to all-ones.
  function automatic logic [31:0] key_sat(input logic [63:0] acc, input int lsb, input int kw);
    logic [63:0] sh;
    logic [63:0] mask;
    sh   = acc >> lsb;
    mask = (64'd1 << kw) - 64'd1;
    if ((sh & ~mask) != 64'd0) key_sat = mask[31:0];
    else key_sat = sh[31:0];
  endfunction

  // Effective list depth: 0 behaves as 1, anything above the built depth behaves as the built depth.
  function automatic logic [4:0] k_clamp(input logic [4:0] k, input int kmax);
    if (k == 5'd0) k_clamp = 5'd1;
    else if (int'(k) > kmax) k_clamp = 5'(kmax);
    else k_clamp = k;
  endfunction

endpackage

// File: rtl/topk_angle_sorter_insert_list.sv
// rtl/topk_angle_sorter_insert_list.sv - descending top-K slot list with single-cycle shift-insert
module topk_insert_list
  import topk_pkg::*;
#(
  parameter int K       = K_DEF,
  parameter int KEY_W   = KEY_W_DEF,
  parameter int ANGLE_W = ANGLE_W_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_ins_v,
  input  logic [KEY_W-1:0]     i_ins_key,
  input  logic [ANGLE_W-1:0]   i_ins_angle,
  input  logic [4:0]           i_k_eff,
  input  logic                 i_clear,
  output logic [K*KEY_W-1:0]   o_next_keys,
  output logic [K*ANGLE_W-1:0] o_next_angles,
  output logic [4:0]           o_next_count
);

  logic [K-1:0]              r_v;
  logic [K-1:0][KEY_W-1:0]   r_key;
  logic [K-1:0][ANGLE_W-1:0] r_ang;

  logic [K-1:0]              w_ge;
  logic [K-1:0]              w_ge_prev;
  logic [K-1:0]              w_sv;
  logic [K-1:0][KEY_W-1:0]   w_skey;
  logic [K-1:0][ANGLE_W-1:0] w_sang;
  logic [K-1:0]              w_v;
  logic [K-1:0][KEY_W-1:0]   w_key;
  logic [K-1:0][ANGLE_W-1:0] w_ang;
  logic [4:0]                w_cnt;

  // The list is kept sorted with valid slots first, so w_ge is a prefix; the first
  // slot not beating the candidate takes it and every later active slot shifts down.
  always_comb begin
    w_ge      = '0;
    w_ge_prev = '1;
    w_sv      = '0;
    w_skey    = '0;
    w_sang    = '0;
    w_v       = r_v;
    w_key     = r_key;
    w_ang     = r_ang;
    w_cnt     = '0;
    for (int i = 0; i < K; i++) w_ge[i] = r_v[i] && (r_key[i] >= i_ins_key);
    for (int i = 1; i < K; i++) begin
      w_ge_prev[i] = w_ge[i-1];
      w_sv[i]      = r_v[i-1];
      w_skey[i]    = r_key[i-1];
      w_sang[i]    = r_ang[i-1];
    end
    for (int i = 0; i < K; i++) begin
      if (i_ins_v && (5'(i) < i_k_eff) && !w_ge[i]) begin
        if (w_ge_prev[i]) begin
          w_v[i]   = 1'b1;
          w_key[i] = i_ins_key;
          w_ang[i] = i_ins_angle;
        end else begin
          w_v[i]   = w_sv[i];
          w_key[i] = w_skey[i];
          w_ang[i] = w_sang[i];
        end
      end
    end
    for (int i = 0; i < K; i++) w_cnt = w_cnt + {4'd0, w_v[i]};
  end

  // Slot registers: a sweep completion snapshots w_* upstream and clears the list here.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst || i_clear) begin
      r_v   <= '0;
      r_key <= '0;
      r_ang <= '0;
    end else begin
      r_v   <= w_v;
      r_key <= w_key;
      r_ang <= w_ang;
    end
  end

  assign o_next_keys   = w_key;
  assign o_next_angles = w_ang;
  assign o_next_count  = w_cnt;

endmodule

// File: rtl/topk_angle_sorter.sv
// rtl/topk_angle_sorter.sv - score accumulator, candidate register, sweep FSM and result handshake
module topk_angle_sorter
  import topk_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int KEY_W   = KEY_W_DEF,
  parameter int KEY_LSB = KEY_LSB_DEF,
  parameter int K       = K_DEF,
  parameter int ANGLE_W = ANGLE_W_DEF,
  parameter int ALPHA_W = ALPHA_W_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_score_valid,
  input  logic [SCORE_W-1:0]   i_score,
  input  logic [ANGLE_W-1:0]   i_angle,
  input  logic [ALPHA_W-1:0]   i_alpha_num,
  input  logic [4:0]           i_k_active,
  input  logic                 i_last_angle,
  input  logic                 i_result_ready,
  output logic                 o_result_valid,
  output logic [K*ANGLE_W-1:0] o_result_angles,
  output logic [K*KEY_W-1:0]   o_result_keys,
  output logic [4:0]           o_result_count,
  output logic                 o_overrun,
  output logic                 o_busy
);

  state_t               r_state, w_state_next;
  logic [ACC_W-1:0]     r_acc, w_acc_next;
  logic [ACC_W:0]       w_sum;
  logic [ALPHA_W-1:0]   r_cnt, w_cnt_next, w_alpha_eff;
  logic [ANGLE_W-1:0]   r_angle, w_angle_cur;
  logic                 r_last, w_last, w_group_end, w_done, w_sweep_start;
  logic [KEY_W-1:0]     w_key;
  logic                 r_cand_v, r_cand_last;
  logic [ANGLE_W-1:0]   r_cand_angle;
  logic [KEY_W-1:0]     r_cand_key;
  logic [4:0]           r_k_eff;
  logic [K*KEY_W-1:0]   w_next_keys;
  logic [K*ANGLE_W-1:0] w_next_angles;
  logic [4:0]           w_next_count;

  // Accumulator datapath: a zero count means the current score opens a new group.
  always_comb begin
    w_alpha_eff = (i_alpha_num == '0) ? ALPHA_W'(1) : i_alpha_num;
    w_sum       = (r_cnt == '0) ? (ACC_W+1)'(i_score) : ({1'b0, r_acc} + (ACC_W+1)'(i_score));
    w_acc_next  = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
    w_cnt_next  = r_cnt + ALPHA_W'(1);
    w_group_end = i_score_valid && (w_cnt_next == w_alpha_eff);
    w_angle_cur = (r_cnt == '0) ? i_angle : r_angle;
    w_last      = r_last | i_last_angle;
    w_key       = KEY_W'(key_sat(64'(w_acc_next), KEY_LSB, KEY_W));
    w_done      = r_cand_v && r_cand_last;
  end

  // Group accumulation; gaps in score_valid hold everything.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_angle <= '0;
      r_last  <= 1'b0;
    end else if (i_score_valid) begin
      r_acc   <= w_acc_next;
      r_angle <= w_angle_cur;
      r_cnt   <= w_group_end ? '0 : w_cnt_next;
      r_last  <= w_group_end ? 1'b0 : w_last;
    end
  end

  // Candidate register carries the angle alongside its key into the list.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cand_v     <= 1'b0;
      r_cand_last  <= 1'b0;
      r_cand_angle <= '0;
      r_cand_key   <= '0;
    end else begin
      r_cand_v <= w_group_end;
      if (w_group_end) begin
        r_cand_last  <= w_last;
        r_cand_angle <= w_angle_cur;
        r_cand_key   <= w_key;
      end
    end
  end

  // Sweep state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else r_state <= w_state_next;
  end

  // Next state; a new sweep may open in the same cycle the previous one's last insert lands.
  always_comb begin
    w_state_next  = r_state;
    w_sweep_start = 1'b0;
    o_busy        = (r_state == S_RUN);
    case (r_state)
      S_IDLE: begin
        if (i_score_valid) begin
          w_state_next  = S_RUN;
          w_sweep_start = 1'b1;
        end
      end
      S_RUN: begin
        if (w_done) begin
          w_sweep_start = i_score_valid;
          w_state_next  = i_score_valid ? S_RUN : S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Active depth is frozen for the whole sweep.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_k_eff <= '0;
    else if (w_sweep_start) r_k_eff <= k_clamp(i_k_active, K);
  end

  topk_insert_list #(
    .K       (K),
    .KEY_W   (KEY_W),
    .ANGLE_W (ANGLE_W)
  ) u_list (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_ins_v       (r_cand_v),
    .i_ins_key     (r_cand_key),
    .i_ins_angle   (r_cand_angle),
    .i_k_eff       (r_k_eff),
    .i_clear       (w_done),
    .o_next_keys   (w_next_keys),
    .o_next_angles (w_next_angles),
    .o_next_count  (w_next_count)
  );

  // Result handshake: completion snapshots the post-insert list; overrun is sticky.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_result_valid  <= 1'b0;
      o_result_angles <= '0;
      o_result_keys   <= '0;
      o_result_count  <= '0;
      o_overrun       <= 1'b0;
    end else if (w_done) begin
      o_result_valid  <= 1'b1;
      o_result_angles <= w_next_angles;
      o_result_keys   <= w_next_keys;
      o_result_count  <= w_next_count;
      if (o_result_valid && !i_result_ready) o_overrun <= 1'b1;
    end else if (o_result_valid && i_result_ready) begin
      o_result_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_topk_angle_sorter.sv
// tb/tb_topk_angle_sorter.sv - directed self-checking bench for topk_angle_sorter
module tb_topk_angle_sorter;

  logic         clk = 1'b0;
  logic         rst;
  logic         score_valid;
  logic [20:0]  score;
  logic [23:0]  angle;
  logic [8:0]   alpha_num;
  logic [4:0]   k_active;
  logic         last_angle;
  logic         result_ready;

  logic         a_valid, b_valid, a_ovr, b_ovr, a_busy, b_busy;
  logic [239:0] a_angles, b_angles;
  logic [79:0]  a_keys, b_keys;
  logic [4:0]   a_count, b_count;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  topk_angle_sorter #(.KEY_LSB(0)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_score_valid(score_valid), .i_score(score),
    .i_angle(angle), .i_alpha_num(alpha_num), .i_k_active(k_active),
    .i_last_angle(last_angle), .i_result_ready(result_ready),
    .o_result_valid(a_valid), .o_result_angles(a_angles), .o_result_keys(a_keys),
    .o_result_count(a_count), .o_overrun(a_ovr), .o_busy(a_busy)
  );

  topk_angle_sorter #(.KEY_LSB(12)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_score_valid(score_valid), .i_score(score),
    .i_angle(angle), .i_alpha_num(alpha_num), .i_k_active(k_active),
    .i_last_angle(last_angle), .i_result_ready(result_ready),
    .o_result_valid(b_valid), .o_result_angles(b_angles), .o_result_keys(b_keys),
    .o_result_count(b_count), .o_overrun(b_ovr), .o_busy(b_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ka(input int i);
    return a_keys[i*8 +: 8];
  endfunction
  function automatic logic [23:0] aa(input int i);
    return a_angles[i*24 +: 24];
  endfunction
  function automatic logic [7:0] kb(input int i);
    return b_keys[i*8 +: 8];
  endfunction
  function automatic logic [23:0] ab(input int i);
    return b_angles[i*24 +: 24];
  endfunction

  // One score for one cycle, starting and ending on a falling edge.
  task automatic put(input logic [20:0] sc, input logic [23:0] ang, input logic lst);
    score_valid = 1'b1;
    score       = sc;
    angle       = ang;
    last_angle  = lst;
    @(negedge clk);
    score_valid = 1'b0;
    last_angle  = 1'b0;
  endtask

  task automatic accept();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; score_valid = 1'b0; score = '0; angle = '0;
    alpha_num = 9'd2; k_active = 5'd10; last_angle = 1'b0; result_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", a_valid, 0);
    check("rst_count", a_count, 0);
    check("rst_overrun", a_ovr, 0);
    check("rst_busy", a_busy, 0);
    check("rst_keys", a_keys[63:0], 0);
    rst = 1'b0;
    @(negedge clk);

    // Ties keep the earlier entry; last flag raised on the first score of its group.
    put(21'd2, 24'h000101, 1'b0); put(21'd3, 24'h000101, 1'b0);
    check("t1_busy", a_busy, 1);
    put(21'd4, 24'h000202, 1'b0); put(21'd5, 24'h000202, 1'b0);
    put(21'd1, 24'h000303, 1'b1); put(21'd4, 24'h000303, 1'b0);
    check("t1_valid_t1", a_valid, 0);
    @(negedge clk);
    check("t1_valid_t2", a_valid, 1);
    check("t1_count", a_count, 3);
    check("t1_k0", ka(0), 9);  check("t1_a0", aa(0), 24'h000202);
    check("t1_k1", ka(1), 5);  check("t1_a1", aa(1), 24'h000101);
    check("t1_k2", ka(2), 5);  check("t1_a2", aa(2), 24'h000303);
    check("t1_k3", ka(3), 0);
    check("t1_busy_done", a_busy, 0);
    accept();
    check("t1_valid_acc", a_valid, 0);

    // Depth 3 keeps only the three largest of twelve.
    alpha_num = 9'd1; k_active = 5'd3;
    for (int n = 1; n <= 12; n++) put(21'(n), 24'h000100 + 24'(n), n == 12);
    @(negedge clk);
    check("t2_count", a_count, 3);
    check("t2_k0", ka(0), 12); check("t2_a0", aa(0), 24'h00010C);
    check("t2_k1", ka(1), 11); check("t2_k2", ka(2), 10);
    check("t2_a2", aa(2), 24'h00010A);
    for (int i = 3; i < 10; i++) begin
      check($sformatf("t2_kz%0d", i), ka(i), 0);
      check($sformatf("t2_az%0d", i), aa(i), 0);
    end
    accept();

    // Saturation on the KEY_LSB=12 instance; wrap-around would give the third group key 0.
    alpha_num = 9'd4; k_active = 5'd10;
    repeat (4) put(21'h1FFFFF, 24'h0000A1, 1'b0);
    repeat (3) put(21'h001000, 24'h0000A2, 1'b0);
    put(21'h0, 24'h0000A2, 1'b0);
    put(21'h1FFFFF, 24'h0000A3, 1'b1); put(21'h1, 24'h0000A3, 1'b0);
    put(21'h0, 24'h0000A3, 1'b0); put(21'h0, 24'h0000A3, 1'b0);
    @(negedge clk);
    check("t3_b_count", b_count, 3);
    check("t3_b_k0", kb(0), 8'hFF); check("t3_b_a0", ab(0), 24'h0000A1);
    check("t3_b_k1", kb(1), 8'hFF); check("t3_b_a1", ab(1), 24'h0000A3);
    check("t3_b_k2", kb(2), 8'h03);
    check("t3_a_k2", ka(2), 8'hFF);
    accept();

    // alpha_num 0 acts as 1, k_active 0 acts as 1.
    alpha_num = 9'd0; k_active = 5'd0;
    put(21'd4, 24'h000091, 1'b0); put(21'd6, 24'h000092, 1'b0); put(21'd2, 24'h000093, 1'b1);
    @(negedge clk);
    check("t0_count", a_count, 1);
    check("t0_k0", ka(0), 6); check("t0_a0", aa(0), 24'h000092);
    check("t0_k1", ka(1), 0);
    accept();

    // Full-rate stream, then a second sweep starting in the final insert cycle.
    alpha_num = 9'd1; k_active = 5'd10;
    put(21'd3, 24'h000031, 1'b0); put(21'd7, 24'h000032, 1'b0);
    put(21'd7, 24'h000033, 1'b0); put(21'd1, 24'h000034, 1'b1);
    put(21'd2, 24'h000041, 1'b0);
    check("t4_valid", a_valid, 1);
    check("t4_count", a_count, 4);
    check("t4_k0", ka(0), 7); check("t4_a0", aa(0), 24'h000032);
    check("t4_k1", ka(1), 7); check("t4_a1", aa(1), 24'h000033);
    check("t4_k2", ka(2), 3); check("t4_k3", ka(3), 1);
    result_ready = 1'b1;
    put(21'd8, 24'h000042, 1'b1);
    result_ready = 1'b0;
    check("t4_valid_acc", a_valid, 0);
    @(negedge clk);
    check("t4s2_valid", a_valid, 1);
    check("t4s2_count", a_count, 2);
    check("t4s2_k0", ka(0), 8); check("t4s2_a0", aa(0), 24'h000042);
    check("t4s2_k1", ka(1), 2); check("t4s2_k2", ka(2), 0);
    check("t4s2_overrun", a_ovr, 0);
    accept();

    // Two completions without acceptance.
    put(21'd5, 24'h000051, 1'b1);
    @(negedge clk);
    check("t5_valid1", a_valid, 1);
    check("t5_ovr1", a_ovr, 0);
    put(21'd6, 24'h000061, 1'b1);
    @(negedge clk);
    check("t5_ovr2", a_ovr, 1);
    check("t5_valid2", a_valid, 1);
    check("t5_k0", ka(0), 6); check("t5_a0", aa(0), 24'h000061);
    accept();
    check("t5_valid_acc", a_valid, 0);
    check("t5_ovr_sticky", a_ovr, 1);

    // Reset mid-group and mid-sweep.
    alpha_num = 9'd2;
    put(21'd4, 24'h000071, 1'b0); put(21'd5, 24'h000071, 1'b0);
    put(21'd100, 24'h000072, 1'b0);
    rst = 1'b1;
    #1;
    check("t6_valid", a_valid, 0);
    check("t6_count", a_count, 0);
    check("t6_ovr", a_ovr, 0);
    check("t6_busy", a_busy, 0);
    check("t6_k0", ka(0), 0);
    check("t6_a0", aa(0), 0);
    @(negedge clk);
    rst = 1'b0;
    put(21'd1, 24'h000081, 1'b1); put(21'd2, 24'h000081, 1'b0);
    @(negedge clk);
    check("t6_post_count", a_count, 1);
    check("t6_post_k0", ka(0), 3); check("t6_post_a0", aa(0), 24'h000081);
    check("t6_post_k1", ka(1), 0);
    check("t6_post_ovr", a_ovr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
